// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller.
// Holds the FSM encodings, the NOP word and the legal stall/flush ranges.
package hazard_pkg;

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] LU_STALL = 2'd1;
  localparam logic [1:0] FLUSH    = 2'd2;
  localparam logic [1:0] FREEZE   = 2'd3;

  localparam logic [31:0] NOP = 32'h0;

  localparam int LOAD_LAT_MIN = 1;
  localparam int LOAD_LAT_MAX = 7;
  localparam int FLUSH_MIN    = 1;
  localparam int FLUSH_MAX    = 7;

  function automatic logic [2:0] clamp3(
    input int v,
    input int lo,
    input int hi
  );
    int r;
    r = (v < lo) ? lo : ((v > hi) ? hi : v);
    return 3'(r);
  endfunction

endpackage

// File: rtl/hazard_ctl_detect.sv
// Load-use comparator: EX load whose destination feeds an ID operand.
// Register 0 is deliberately not exempt.
module hazard_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] i_top_addr,
  input  logic                  i_top_used,
  input  logic [REG_ADDR_W-1:0] i_bot_addr,
  input  logic                  i_bot_used,
  input  logic [REG_ADDR_W-1:0] i_ex_dest,
  input  logic                  i_ex_load,
  output logic                  o_lu_hz
);

  logic w_top_hit;
  logic w_bot_hit;

  assign w_top_hit = i_top_used && (i_top_addr == i_ex_dest);
  assign w_bot_hit = i_bot_used && (i_bot_addr == i_ex_dest);
  assign o_lu_hz   = i_ex_load && (w_top_hit || w_bot_hit);

endmodule

// File: rtl/hazard_ctl.sv
// Pipeline hazard/sequencing FSM with freeze, redirect flush and
// load-use stall, plus a saturating stall-cycle counter.
module hazard_ctl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 2,
  parameter int PERF_W       = 16
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic [REG_ADDR_W-1:0] id_top_addr,
  input  logic                  id_top_used,
  input  logic [REG_ADDR_W-1:0] id_bot_addr,
  input  logic                  id_bot_used,
  input  logic [REG_ADDR_W-1:0] ex_dest_addr,
  input  logic                  ex_is_load,
  input  logic                  ex_redirect,
  input  logic                  mem_busy,
  output logic                  pc_hold,
  output logic                  pc_redirect,
  output logic                  if_id_hold,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  id_ex_hold,
  output logic                  ex_mem_hold,
  output logic                  mem_wb_bubble,
  output logic [1:0]            busy_state,
  output logic [PERF_W-1:0]     stall_cycles
);

  localparam logic [2:0] LL =
    clamp3(LOAD_LAT, LOAD_LAT_MIN, LOAD_LAT_MAX);
  localparam logic [2:0] FC =
    clamp3(FLUSH_CYCLES, FLUSH_MIN, FLUSH_MAX);

  logic [1:0]        r_state;
  logic [1:0]        r_ret;
  logic [2:0]        r_cnt;
  logic [PERF_W-1:0] r_stall;

  logic       w_lu_hz;
  logic [1:0] w_cur;
  logic [1:0] w_nstate;
  logic [1:0] w_nret;
  logic [2:0] w_ncnt;
  logic [7:0] w_ctl;

  hazard_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_detect (
    .i_top_addr(id_top_addr),
    .i_top_used(id_top_used),
    .i_bot_addr(id_bot_addr),
    .i_bot_used(id_bot_used),
    .i_ex_dest (ex_dest_addr),
    .i_ex_load (ex_is_load),
    .o_lu_hz   (w_lu_hz)
  );

  // FREEZE resumes the state it interrupted once memory is ready.
  assign w_cur = (r_state == FREEZE) ? r_ret : r_state;

  // w_ctl: pc_hold, pc_redirect, if_id_hold, if_id_flush,
  //        id_ex_bubble, id_ex_hold, ex_mem_hold, mem_wb_bubble
  always_comb begin
    w_ctl    = 8'b0;
    w_nstate = r_state;
    w_nret   = r_ret;
    w_ncnt   = r_cnt;
    if (mem_busy) begin
      w_ctl    = 8'b1010_0111;
      w_nstate = FREEZE;
      if (r_state != FREEZE) w_nret = r_state;
    end else if (ex_redirect) begin
      w_ctl = 8'b0101_1000;
      if (FC > 3'd1) begin
        w_nstate = FLUSH;
        w_ncnt   = FC - 3'd1;
      end else begin
        w_nstate = RUN;
      end
    end else begin
      unique case (1'b1)
        (w_cur == LU_STALL): begin
          w_ctl    = 8'b1010_1000;
          w_ncnt   = r_cnt - 3'd1;
          w_nstate = (r_cnt <= 3'd1) ? RUN : LU_STALL;
        end
        (w_cur == FLUSH): begin
          w_ctl    = 8'b0001_1000;
          w_ncnt   = r_cnt - 3'd1;
          w_nstate = (r_cnt <= 3'd1) ? RUN : FLUSH;
        end
        default: begin
          w_nstate = RUN;
          if (w_lu_hz) begin
            w_ctl = 8'b1010_1000;
            if (LL > 3'd1) begin
              w_nstate = LU_STALL;
              w_ncnt   = LL - 3'd1;
            end
          end
        end
      endcase
    end
  end

  assign pc_hold       = nreset && w_ctl[7];
  assign pc_redirect   = nreset && w_ctl[6];
  assign if_id_hold    = nreset && w_ctl[5];
  assign if_id_flush   = nreset && w_ctl[4];
  assign id_ex_bubble  = nreset && w_ctl[3];
  assign id_ex_hold    = nreset && w_ctl[2];
  assign ex_mem_hold   = nreset && w_ctl[1];
  assign mem_wb_bubble = nreset && w_ctl[0];
  assign busy_state    = nreset ? r_state : RUN;
  assign stall_cycles  = r_stall;

  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_state <= RUN;
      r_ret   <= RUN;
      r_cnt   <= 3'd0;
      r_stall <= '0;
    end else begin
      r_state <= w_nstate;
      r_ret   <= w_nret;
      r_cnt   <= w_ncnt;
      if (pc_hold && (r_stall != {PERF_W{1'b1}}))
        r_stall <= r_stall + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctl.sv
// Scoreboard bench for hazard_ctl: directed vectors push expected
// controls; a negedge monitor pops and compares every cycle.
module tb_hazard_ctl;

  localparam logic [7:0] C_ID = 8'b0000_0000;
  localparam logic [7:0] C_LU = 8'b1010_1000;
  localparam logic [7:0] C_RD = 8'b0101_1000;
  localparam logic [7:0] C_FL = 8'b0001_1000;
  localparam logic [7:0] C_FZ = 8'b1010_0111;

  typedef struct {
    logic [7:0]  ctl;
    logic [1:0]  st;
    logic [15:0] cnt;
    logic [3:0]  sat;
    string       nm;
  } exp_t;

  logic       clk = 1'b0;
  logic       nreset;
  logic [4:0] top_a, bot_a, dest;
  logic       top_u, bot_u, ld, rd, mb;

  logic       d_pch, d_pcr, d_ifh, d_iff, d_idb, d_idh, d_exh, d_mwb;
  logic [1:0] d_st;
  logic [15:0] d_cnt;
  logic       s_pch, s_pcr, s_ifh, s_iff, s_idb, s_idh, s_exh, s_mwb;
  logic [1:0] s_st;
  logic [3:0] s_cnt;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   m_cnt = 0;
  int   m_sat = 0;

  always #5 clk = ~clk;

  hazard_ctl #(
    .REG_ADDR_W(5), .LOAD_LAT(2), .FLUSH_CYCLES(2), .PERF_W(16)
  ) u_dut (
    .clock(clk), .nreset(nreset),
    .id_top_addr(top_a), .id_top_used(top_u),
    .id_bot_addr(bot_a), .id_bot_used(bot_u),
    .ex_dest_addr(dest), .ex_is_load(ld),
    .ex_redirect(rd), .mem_busy(mb),
    .pc_hold(d_pch), .pc_redirect(d_pcr),
    .if_id_hold(d_ifh), .if_id_flush(d_iff),
    .id_ex_bubble(d_idb), .id_ex_hold(d_idh),
    .ex_mem_hold(d_exh), .mem_wb_bubble(d_mwb),
    .busy_state(d_st), .stall_cycles(d_cnt)
  );

  hazard_ctl #(
    .REG_ADDR_W(5), .LOAD_LAT(2), .FLUSH_CYCLES(2), .PERF_W(4)
  ) u_sat (
    .clock(clk), .nreset(nreset),
    .id_top_addr(top_a), .id_top_used(top_u),
    .id_bot_addr(bot_a), .id_bot_used(bot_u),
    .ex_dest_addr(dest), .ex_is_load(ld),
    .ex_redirect(rd), .mem_busy(mb),
    .pc_hold(s_pch), .pc_redirect(s_pcr),
    .if_id_hold(s_ifh), .if_id_flush(s_iff),
    .id_ex_bubble(s_idb), .id_ex_hold(s_idh),
    .ex_mem_hold(s_exh), .mem_wb_bubble(s_mwb),
    .busy_state(s_st), .stall_cycles(s_cnt)
  );

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      logic [7:0] act;
      e   = q.pop_front();
      act = {d_pch, d_pcr, d_ifh, d_iff, d_idb, d_idh, d_exh, d_mwb};
      n_chk++;
      if (act !== e.ctl || d_st !== e.st) begin
        n_fail++;
        $display("FAIL %s ctl/state: got %b/%0d want %b/%0d",
                 e.nm, act, d_st, e.ctl, e.st);
      end
      n_chk++;
      if (d_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL %s stall_cycles: got %0d want %0d",
                 e.nm, d_cnt, e.cnt);
      end
      n_chk++;
      if (s_cnt !== e.sat) begin
        n_fail++;
        $display("FAIL %s sat_cycles: got %0d want %0d",
                 e.nm, s_cnt, e.sat);
      end
      n_chk++;
      if ((d_idh && d_idb) || (d_ifh && d_iff)) begin
        n_fail++;
        $display("FAIL %s invariant: got idh=%b idb=%b ifh=%b iff=%b want no pair",
                 e.nm, d_idh, d_idb, d_ifh, d_iff);
      end
    end
  end

  task automatic step(
    input logic       r,
    input logic       l,
    input logic [4:0] de,
    input logic [4:0] ta,
    input logic       tu,
    input logic [4:0] ba,
    input logic       bu,
    input logic       re,
    input logic       m,
    input logic [7:0] ctl,
    input logic [1:0] st,
    input string      nm
  );
    exp_t e;
    @(posedge clk);
    #1;
    nreset = r; ld = l; dest = de;
    top_a = ta; top_u = tu; bot_a = ba; bot_u = bu;
    rd = re; mb = m;
    e.ctl = ctl;
    e.st  = st;
    e.cnt = 16'(m_cnt);
    e.sat = 4'(m_sat);
    e.nm  = nm;
    q.push_back(e);
    if (!r) begin
      m_cnt = 0;
      m_sat = 0;
    end else if (ctl[7]) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_sat < 15) m_sat++;
    end
  endtask

  task automatic idle(input logic [7:0] ctl, input logic [1:0] st,
                      input string nm);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, ctl, st, nm);
  endtask

  initial begin
    nreset = 0; ld = 0; dest = 0; top_a = 0; top_u = 0;
    bot_a = 0; bot_u = 0; rd = 0; mb = 0;
    @(posedge clk);
    repeat (3) step(0, 1, 5, 5, 1, 0, 0, 1, 1, C_ID, 0, "reset");
    idle(C_ID, 0, "post_reset");
    idle(C_ID, 0, "post_reset");
    step(1, 1, 5, 5, 1, 0, 0, 0, 0, C_LU, 0, "lu_top_c0");
    step(1, 1, 5, 5, 1, 0, 0, 0, 0, C_LU, 1, "lu_top_c1");
    idle(C_ID, 0, "lu_top_end");
    step(1, 1, 5, 5, 0, 0, 0, 0, 0, C_ID, 0, "lu_unused");
    step(1, 0, 5, 5, 1, 0, 0, 0, 0, C_ID, 0, "lu_not_load");
    step(1, 1, 7, 3, 1, 7, 1, 0, 0, C_LU, 0, "lu_bot_c0");
    idle(C_LU, 1, "lu_bot_c1");
    idle(C_ID, 0, "lu_bot_end");
    step(1, 1, 0, 0, 1, 0, 0, 0, 0, C_LU, 0, "lu_r0_c0");
    idle(C_LU, 1, "lu_r0_c1");
    idle(C_ID, 0, "lu_r0_end");
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, C_RD, 0, "redir_c0");
    idle(C_FL, 2, "redir_c1");
    idle(C_ID, 0, "redir_end");
    step(1, 1, 5, 5, 1, 0, 0, 1, 0, C_RD, 0, "redir_lu_c0");
    idle(C_FL, 2, "redir_lu_c1");
    idle(C_ID, 0, "redir_lu_end");
    step(1, 1, 5, 5, 1, 0, 0, 0, 0, C_LU, 0, "abort_c0");
    step(1, 1, 5, 5, 1, 0, 0, 1, 0, C_RD, 1, "abort_c1");
    idle(C_FL, 2, "abort_flush");
    idle(C_ID, 0, "abort_end");
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, C_RD, 0, "frz_fl_redir");
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, C_FZ, 2, "frz_fl_f0");
    for (int i = 0; i < 3; i++)
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, C_FZ, 3, "frz_fl_fn");
    idle(C_FL, 3, "frz_fl_resume");
    idle(C_ID, 0, "frz_fl_end");
    step(1, 1, 5, 5, 1, 0, 0, 0, 0, C_LU, 0, "frz_lu_c0");
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, C_FZ, 1, "frz_lu_f0");
    idle(C_LU, 3, "frz_lu_resume");
    idle(C_ID, 0, "frz_lu_end");
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, C_FZ, 0, "sat_f0");
    for (int i = 0; i < 19; i++)
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, C_FZ, 3, "sat_fn");
    idle(C_ID, 3, "sat_exit");
    idle(C_ID, 0, "sat_hold");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, C_ID, 0, "sat_reset");
    idle(C_ID, 0, "sat_cleared");
    repeat (3) @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d queued want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctl.md
Name: hazard_ctl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage datapath.
- Drives the hold, bubble and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC.
- Detects load-use data hazards, redirects (branch/call/return resolved in EX) and multi-cycle memory waits, then sequences the required stall/flush cycles with a small FSM.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
- REG_ADDR_W, 5, width of register-file addresses.
- LOAD_LAT, 1, bubble cycles inserted on a load-use hazard; legal range 1..7.
- FLUSH_CYCLES, 2, cycles IF/ID is flushed after a redirect; legal range 1..7.
- PERF_W, 16, width of the stall performance counter.

Ports:
- clock  in  1  system clock
- nreset  in  1  synchronous active-low reset
- id_top_addr  in  REG_ADDR_W  source register read by the ALU top operand in ID
- id_top_used  in  1  id_top_addr is a real operand
- id_bot_addr  in  REG_ADDR_W  source register read by the ALU bottom operand in ID
- id_bot_used  in  1  id_bot_addr is a real operand
- ex_dest_addr  in  REG_ADDR_W  destination register of the instruction in EX
- ex_is_load  in  1  EX instruction writes the register file from memory
- ex_redirect  in  1  EX resolved a taken branch, call or return
- mem_busy  in  1  memory stage (main, frame buffer, call stack, program memory) needs more cycles
- pc_hold  out  1  PC keeps its value
- pc_redirect  out  1  PC loads the EX target
- if_id_hold  out  1  IF/ID keeps its contents
- if_id_flush  out  1  IF/ID clears to NOP
- id_ex_bubble  out  1  drives the id_ex stall input, which zeroes the register to a NOP
- id_ex_hold  out  1  ID/EX keeps its contents
- ex_mem_hold  out  1  EX/MEM keeps its contents
- mem_wb_bubble  out  1  MEM/WB captures a NOP
- busy_state  out  2  current FSM state, for debug
- stall_cycles  out  PERF_W  saturating count of cycles with pc_hold=1

Behaviour:
- All outputs are combinational from the state and the current inputs. Exception: stall_cycles is a register.
- At reset, or whenever nreset=0 at a clock edge:
  - state goes to RUN, cnt=0, stall_cycles=0.
  - While nreset=0, all control outputs are 0.
- FSM states: RUN=0, LU_STALL=1, FLUSH=2, FREEZE=3. A 3-bit down-counter cnt is shared by LU_STALL and FLUSH.
- Hazard definitions:
  - lu_hz = ex_is_load and ((id_top_used and id_top_addr==ex_dest_addr) or (id_bot_used and id_bot_addr==ex_dest_addr)).
  - Register address 0 is not exempt.
- Priority, evaluated every cycle in every state: mem_busy > ex_redirect > lu_hz.
- FREEZE condition (mem_busy=1), in any state:
  - Outputs: pc_hold, if_id_hold, id_ex_hold, ex_mem_hold and mem_wb_bubble = 1; all other outputs = 0.
  - Next state is FREEZE; cnt is preserved.
  - When mem_busy drops, the FSM returns to the state it froze in (saved in ret_state) and continues that state's remaining cnt.
- Redirect (ex_redirect=1, mem_busy=0), in any state:
  - Outputs: pc_redirect=1, if_id_flush=1, id_ex_bubble=1.
  - If FLUSH_CYCLES>1: next state FLUSH with cnt=FLUSH_CYCLES-1; otherwise next state RUN.
  - A redirect aborts any LU_STALL in progress.
- FLUSH state, no higher-priority event:
  - Outputs: if_id_flush=1, id_ex_bubble=1.
  - cnt decrements; at cnt==1, next state is RUN.
- Load-use in RUN (lu_hz=1, no higher event):
  - Outputs: pc_hold=1, if_id_hold=1, id_ex_bubble=1.
  - If LOAD_LAT>1: next state LU_STALL with cnt=LOAD_LAT-1.
- LU_STALL state:
  - Outputs are the same as for a load-use in RUN.
  - cnt decrements; at cnt==1, next state is RUN.
  - lu_hz is ignored while in LU_STALL.
- RUN with no event: all control outputs are 0.
- Invariants:
  - id_ex_hold and id_ex_bubble are never both 1.
  - if_id_hold and if_id_flush are never both 1.
- stall_cycles increments on each clock edge where pc_hold=1 and nreset=1. It saturates at all-ones and does not wrap.

Decomposition:
- Shared package hazard_pkg holds:
  - state encodings RUN/LU_STALL/FLUSH/FREEZE;
  - the NOP instruction word 32'h0;
  - the legal ranges of LOAD_LAT and FLUSH_CYCLES.
- Natural sub-module: hazard_detect, the purely combinational lu_hz comparator. The FSM and the counters stay in hazard_ctl.

Test Plan:
- Reset: hold nreset=0 for 3 cycles with mem_busy=1 and ex_redirect=1.
  - Required: all outputs 0 and busy_state=0. After release with idle inputs, outputs stay 0.
- Load-use, LOAD_LAT=2: ex_is_load=1, ex_dest_addr=5, id_top_addr=5, id_top_used=1.
  - Required: pc_hold, if_id_hold and id_ex_bubble are 1 for exactly 2 cycles, then 0.
  - Required: stall_cycles=2.
  - Repeat with id_top_used=0: no stall.
- Redirect, FLUSH_CYCLES=2: pulse ex_redirect for 1 cycle.
  - Required: pc_redirect=1 for 1 cycle; if_id_flush and id_ex_bubble = 1 for 2 cycles; busy_state sequence 0, 2, 0.
- Simultaneous events: ex_redirect=1 and lu_hz=1 in the same cycle.
  - Required: redirect outputs only, pc_hold=0.
  - Redirect in the first LU_STALL cycle: the stall is aborted and the FSM enters FLUSH.
- Freeze mid-flush: in FLUSH cycle 1, assert mem_busy for 4 cycles.
  - Required: 4 cycles of freeze outputs (id_ex_hold=1, id_ex_bubble=0), then 1 remaining flush cycle, then RUN.
- Saturation, PERF_W=4: sustain mem_busy for 20 cycles.
  - Required: stall_cycles stops at 15.
  - Required: nreset=0 for 1 cycle clears it to 0.
